// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: branch-type codes, fetch constants and redirect FSM encoding.
package mips_pipe_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    StIdle = 1'b0,
    StPend = 1'b1
  } redir_state_e;

  // Codes 110/111 are unused encodings and must behave like BR_NONE.
  function automatic logic is_branch(input logic [2:0] br_ctrl);
    return (br_ctrl >= BR_BEQ) && (br_ctrl <= BR_BLTZ);
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational PC-relative branch target: id_pc + 4 + (sext(id_imm) << 2), wrapping mod 2^32.
module branch_target_adder
  import mips_pipe_pkg::*;
(
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm,
  output logic [31:0] br_target
);

  logic [31:0] offset;

  assign offset    = {{14{id_imm[15]}}, id_imm, 2'b00};
  assign br_target = id_pc + PC_STEP + offset;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, IF/ID flush, one-entry redirect buffer for
// fetch back-pressure, and branch performance counters.
module pc_redirect_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_if,
  input  logic             fetch_ready,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm,
  input  logic [2:0]       br_ctrl,
  input  logic             br_taken,
  input  logic             jump_en,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc,
  output logic             if_id_flush,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] br_eval_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  redir_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pend_target_q;
  logic [CNT_W-1:0] br_eval_cnt_q;
  logic [CNT_W-1:0] br_taken_cnt_q;

  logic [31:0] br_target;
  logic [31:0] redir_tgt;
  logic        is_br;
  logic        id_live;
  logic        redir_req;

  branch_target_adder u_branch_target_adder (
    .id_pc     (id_pc),
    .id_imm    (id_imm),
    .br_target (br_target)
  );

  // An ID instruction only acts when not stalled and no older redirect is still buffered.
  assign is_br     = is_branch(br_ctrl);
  assign id_live   = id_valid & ~stall_if & (state_q == StIdle);
  assign redir_req = id_live & (jump_en | (is_br & br_taken));
  assign redir_tgt = jump_en ? jump_target : br_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      pend_target_q  <= '0;
      br_eval_cnt_q  <= '0;
      br_taken_cnt_q <= '0;
    end else if (!stall_if) begin
      if (id_live && is_br) begin
        br_eval_cnt_q <= br_eval_cnt_q + CntOne;
        if (br_taken) br_taken_cnt_q <= br_taken_cnt_q + CntOne;
      end
      if (fetch_ready) begin
        if (redir_req) begin
          pc_q <= redir_tgt;
        end else if (state_q == StPend) begin
          pc_q    <= pend_target_q;
          state_q <= StIdle;
        end else begin
          pc_q <= pc_q + PC_STEP;
        end
      end else if (redir_req) begin
        pend_target_q <= redir_tgt;
        state_q       <= StPend;
      end
    end
  end

  assign pc               = pc_q;
  assign if_id_flush      = redir_req;
  assign redirect_pending = (state_q == StPend);
  assign br_eval_cnt      = br_eval_cnt_q;
  assign br_taken_cnt     = br_taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed, table-driven checks of pc_redirect_unit: sequential fetch, redirects, wrap, buffering.
module tb_pc_redirect_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        fr;
    logic        valid;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [2:0]  ctrl;
    logic        taken;
    logic        jump;
    logic [31:0] jt;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_pend;
    logic [31:0] e_eval;
    logic [31:0] e_tkn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall_if, fetch_ready, id_valid, br_taken, jump_en;
  logic [31:0] id_pc, jump_target, pc;
  logic [15:0] id_imm;
  logic [2:0]  br_ctrl;
  logic        if_id_flush, redirect_pending;
  logic [31:0] br_eval_cnt, br_taken_cnt;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall_if         (stall_if),
    .fetch_ready      (fetch_ready),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_imm           (id_imm),
    .br_ctrl          (br_ctrl),
    .br_taken         (br_taken),
    .jump_en          (jump_en),
    .jump_target      (jump_target),
    .pc               (pc),
    .if_id_flush      (if_id_flush),
    .redirect_pending (redirect_pending),
    .br_eval_cnt      (br_eval_cnt),
    .br_taken_cnt     (br_taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic st, input logic fr, input logic v,
                              input logic [31:0] ipc, input logic [15:0] imm,
                              input logic [2:0] ctrl, input logic tk, input logic j,
                              input logic [31:0] jt, input logic ef, input logic [31:0] epc,
                              input logic ep, input logic [31:0] ee, input logic [31:0] et);
    vec_t x;
    x.rst = r; x.stall = st; x.fr = fr; x.valid = v; x.id_pc = ipc; x.imm = imm;
    x.ctrl = ctrl; x.taken = tk; x.jump = j; x.jt = jt; x.e_flush = ef; x.e_pc = epc;
    x.e_pend = ep; x.e_eval = ee; x.e_tkn = et;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at negedge, check the combinational flush, then check registered state after posedge.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    rst = v.rst; stall_if = v.stall; fetch_ready = v.fr; id_valid = v.valid;
    id_pc = v.id_pc; id_imm = v.imm; br_ctrl = v.ctrl; br_taken = v.taken;
    jump_en = v.jump; jump_target = v.jt;
    #1;
    chk({nm, ".flush"}, {31'd0, if_id_flush}, {31'd0, v.e_flush});
    @(posedge clk);
    #1;
    chk({nm, ".pc"}, pc, v.e_pc);
    chk({nm, ".pend"}, {31'd0, redirect_pending}, {31'd0, v.e_pend});
    chk({nm, ".eval"}, br_eval_cnt, v.e_eval);
    chk({nm, ".taken"}, br_taken_cnt, v.e_tkn);
  endtask

  vec_t tbl[13];

  initial begin
    //               rst st fr v  id_pc         imm       ctrl  tk j  jt            fl pc            pd ev tk
    tbl[0]  = mk(0, 0, 1, 1, 32'h0000_3010, 16'h0004, 3'b001, 1, 0, 32'h0,        1, 32'h0000_3024, 0, 1, 1);
    tbl[1]  = mk(0, 0, 1, 1, 32'h0000_3014, 16'h0004, 3'b010, 0, 0, 32'h0,        0, 32'h0000_3028, 0, 2, 1);
    tbl[2]  = mk(0, 0, 1, 1, 32'h0000_3010, 16'hFFFF, 3'b001, 1, 0, 32'h0,        1, 32'h0000_3010, 0, 3, 2);
    tbl[3]  = mk(0, 0, 1, 1, 32'h0000_0000, 16'h8000, 3'b011, 1, 0, 32'h0,        1, 32'hFFFE_0004, 0, 4, 3);
    tbl[4]  = mk(0, 0, 1, 0, 32'h0000_3010, 16'h0004, 3'b001, 1, 0, 32'h0,        0, 32'hFFFE_0008, 0, 4, 3);
    tbl[5]  = mk(0, 0, 1, 1, 32'h0000_3010, 16'h0004, 3'b110, 1, 0, 32'h0,        0, 32'hFFFE_000C, 0, 4, 3);
    tbl[6]  = mk(0, 1, 1, 1, 32'h0000_3010, 16'h0004, 3'b001, 1, 0, 32'h0,        0, 32'hFFFE_000C, 0, 4, 3);
    tbl[7]  = mk(0, 0, 1, 1, 32'h0000_3010, 16'h0004, 3'b001, 1, 1, 32'h0000_4000, 1, 32'h0000_4000, 0, 5, 4);
    tbl[8]  = mk(0, 0, 1, 1, 32'h0000_4000, 16'h0000, 3'b000, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 5, 4);
    tbl[9]  = mk(0, 0, 1, 0, 32'h0,         16'h0000, 3'b000, 0, 0, 32'h0,        0, 32'h0000_0000, 0, 5, 4);
    tbl[10] = mk(0, 0, 1, 1, 32'h0000_0100, 16'h0001, 3'b100, 1, 0, 32'h0,        1, 32'h0000_0108, 0, 6, 5);
    tbl[11] = mk(0, 0, 0, 1, 32'h0000_0108, 16'h0004, 3'b101, 0, 0, 32'h0,        0, 32'h0000_0108, 0, 7, 5);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,         16'h0000, 3'b000, 0, 0, 32'h0,        0, 32'h0000_0108, 0, 7, 5);

    rst = 1'b1; stall_if = 1'b0; fetch_ready = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_imm = '0; br_ctrl = '0; br_taken = 1'b0; jump_en = 1'b0; jump_target = '0;

    // Reset, then three sequential fetches.
    run_vec(mk(1, 0, 0, 0, 32'h0, 16'h0, 3'b000, 0, 0, 32'h0, 0, 32'h0000_3000, 0, 0, 0), "reset");
    run_vec(mk(0, 0, 1, 0, 32'h0, 16'h0, 3'b000, 0, 0, 32'h0, 0, 32'h0000_3004, 0, 0, 0), "seq1");
    run_vec(mk(0, 0, 1, 0, 32'h0, 16'h0, 3'b000, 0, 0, 32'h0, 0, 32'h0000_3008, 0, 0, 0), "seq2");
    run_vec(mk(0, 0, 1, 0, 32'h0, 16'h0, 3'b000, 0, 0, 32'h0, 0, 32'h0000_300C, 0, 0, 0), "seq3");

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Redirect buffered while fetch is not ready; younger redirects ignored while pending.
    run_vec(mk(0, 0, 0, 1, 32'h0000_3010, 16'h0004, 3'b001, 1, 0, 32'h0,
               1, 32'h0000_0108, 1, 8, 6), "pend_set");
    run_vec(mk(0, 0, 0, 1, 32'h0000_3014, 16'h0000, 3'b000, 0, 1, 32'h0000_5000,
               0, 32'h0000_0108, 1, 8, 6), "pend_jump_ign");
    run_vec(mk(0, 0, 0, 1, 32'h0000_3010, 16'h0004, 3'b001, 1, 0, 32'h0,
               0, 32'h0000_0108, 1, 8, 6), "pend_br_ign");
    run_vec(mk(0, 0, 1, 1, 32'h0000_3014, 16'h0000, 3'b000, 0, 1, 32'h0000_5000,
               0, 32'h0000_3024, 0, 8, 6), "pend_release");

    // Stall holds a pending redirect; reset discards it.
    run_vec(mk(0, 0, 0, 1, 32'h0000_0000, 16'h0002, 3'b010, 1, 0, 32'h0,
               1, 32'h0000_3024, 1, 9, 7), "pend2_set");
    run_vec(mk(0, 1, 1, 1, 32'h0000_0000, 16'h0002, 3'b010, 1, 0, 32'h0,
               0, 32'h0000_3024, 1, 9, 7), "pend2_stall");
    run_vec(mk(1, 0, 1, 0, 32'h0, 16'h0, 3'b000, 0, 0, 32'h0,
               0, 32'h0000_3000, 0, 0, 0), "pend2_rst");
    run_vec(mk(0, 0, 1, 0, 32'h0, 16'h0, 3'b000, 0, 0, 32'h0,
               0, 32'h0000_3004, 0, 0, 0), "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
